skew_feed_ctrl: RTL

SKEW_FEED_CTRL -- requirements
Module: skew_feed_ctrl

---
 rtl/skew_pkg.sv | 8 +
 rtl/skew_feed_ctrl.sv | 72 +++++++
 2 files changed

// File: rtl/skew_pkg.sv
// skew_pkg: shared FSM state type and size defaults for the skew feed controller
package skew_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, FLUSH, DONE} state_e;
  localparam int N_DEF = 32;
  function automatic int drain_len(input int n);
    return 2 * n + 2;
  endfunction
endpackage

// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: latches a row, clears/loads/drains a downstream skew FIFO and reports completion
module skew_feed_ctrl
  import skew_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DRAIN_LEN = drain_len(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0][7:0] in_data,
  input  logic              stall,
  input  logic              abort,
  output logic [N-1:0][7:0] fifo_data,
  output logic              fifo_clr,
  output logic              fifo_wrt,
  output logic              fifo_rd,
  output logic              array_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  localparam int CW = $clog2(DRAIN_LEN + 1);
  state_e        r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_en;
  // strobes are suppressed while reset or an abort overrides the current state
  assign w_en = !rst && !abort;
  assign in_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign fifo_clr = w_en && r_state == CLEAR;
  assign fifo_wrt = w_en && r_state == LOAD;
  assign fifo_rd = w_en && r_state == DRAIN && !stall;
  assign done = w_en && r_state == DONE;
  // next-state decode; abort outranks every advance outside IDLE
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    w_nxt = in_valid ? CLEAR : IDLE;
      CLEAR:   w_nxt = LOAD;
      LOAD:    w_nxt = r_cnt == CW'(N - 1) ? DRAIN : LOAD;
      DRAIN:   w_nxt = (!stall && r_cnt == CW'(DRAIN_LEN - 1)) ? FLUSH : DRAIN;
      FLUSH:   w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (abort && r_state != IDLE) w_nxt = IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  // shared write/read counter, cleared whenever a new state is entered
  always_ff @(posedge clk) begin
    if (rst || w_nxt != r_state) r_cnt <= '0;
    else if (r_state == LOAD || fifo_rd) r_cnt <= r_cnt + CW'(1);
  end
  // row latch, read-valid pipeline stage and abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data   <= '0;
      array_valid <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      if (in_valid && r_state == IDLE) fifo_data <= in_data;
      array_valid <= fifo_rd;
      aborted     <= abort && r_state != IDLE;
    end
  end
endmodule
